// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer.sv
// PISO serializer: a word accepted on valid_i&ready_o appears on q_o the next cycle, one bit per tick_i.
// ready_o rises only in IDLE or on the final bit's tick, so back-to-back words stream with no gap bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             tick_i,
  output logic             q_o,
  output logic             q_valid_o,
  output logic             last_o,
  output logic             done_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             at_last;
  logic             wrap;
  logic             accept;
  logic             out_bit;

  assign at_last = (cnt_q == LAST_CNT);
  // Final bit being consumed this cycle: the only point in SHIFT where a new word may enter.
  assign wrap    = (state_q == SHIFT) && tick_i && at_last;
  assign ready_o = (state_q == IDLE) || wrap;
  assign accept  = valid_i && ready_o;
  assign out_bit = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
  assign done_o  = done_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (wrap)   state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_valid_o = 1'b0;
    q_o       = 1'b0;
    last_o    = 1'b0;
    if (state_q == SHIFT) begin
      q_valid_o = 1'b1;
      q_o       = out_bit;
      last_o    = at_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= wrap;
      if (accept) begin
        sreg_q <= data_i;
        cnt_q  <= '0;
      end else if ((state_q == SHIFT) && tick_i && !at_last) begin
        sreg_q <= LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per parallel word; SHALL be >= 2.
REQ-002 Parameter LSB_FIRST, default 0: 0 = MSB transmitted first, 1 = LSB transmitted first.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 data_i  input  WIDTH  parallel word to serialize.
REQ-006 valid_i  input  1  data_i is valid.
REQ-007 ready_o  output  1  block can accept a word this cycle.
REQ-008 tick_i  input  1  bit-advance enable; the current bit is consumed only on cycles where it is 1.
REQ-009 q_o  output  1  serial data bit.
REQ-010 q_valid_o  output  1  q_o carries a valid bit.
REQ-011 last_o  output  1  q_o is the final bit of the current word.
REQ-012 done_o  output  1  one-cycle pulse after a word's final bit is consumed.

Function
REQ-013 FSM states SHALL be IDLE and SHIFT.
REQ-014 Acceptance SHALL occur on a rising edge where valid_i=1 and ready_o=1.
- Load data_i into the shift register.
- Clear the bit counter.
- Enter SHIFT.
REQ-015 ready_o SHALL be 1 in IDLE.
- In SHIFT, ready_o SHALL be 1 only when bit_cnt = WIDTH-1 and tick_i = 1.
- ready_o is combinational from state, counter and tick_i.
REQ-016 In SHIFT, q_valid_o SHALL be 1.
- q_o SHALL equal sreg[WIDTH-1] when LSB_FIRST=0, or sreg[0] when LSB_FIRST=1.
REQ-017 The first bit SHALL appear on q_o the cycle after acceptance (latency 1).
REQ-018 When tick_i=1 in SHIFT and bit_cnt < WIDTH-1:
- Shift the register one position toward the output end, filling with 0.
- Increment bit_cnt.
REQ-019 When tick_i=0 in SHIFT, sreg, bit_cnt, q_o and last_o SHALL hold.
REQ-020 last_o SHALL equal q_valid_o AND (bit_cnt = WIDTH-1).
REQ-021 When tick_i=1 with bit_cnt = WIDTH-1:
- If valid_i=1, accept the new word and stay in SHIFT with no gap bit.
- Otherwise, go to IDLE.
- In both cases, done_o SHALL pulse on the next cycle.
REQ-022 In IDLE, q_o, q_valid_o and last_o SHALL be 0, and tick_i SHALL be ignored.
REQ-023 valid_i while ready_o=0 SHALL NOT sample data_i or alter any state.
REQ-024 bit_cnt width SHALL be $clog2(WIDTH); bit_cnt SHALL never exceed WIDTH-1.

Reset
REQ-025 While rst_i=0, without waiting for a clock edge:
- State SHALL be IDLE.
- sreg and bit_cnt SHALL be 0.
- q_o=0, q_valid_o=0, last_o=0, done_o=0, ready_o=1.
REQ-026 Reset during SHIFT SHALL discard the in-flight word with no done_o pulse.
REQ-027 After reset release, the first accepted word SHALL start from its first bit.

Structure
REQ-028 Package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT).
REQ-029 The block SHALL be a single module with no sub-module.
- The shift register, counter and FSM are too small to justify a split.

Verification (WIDTH=8 unless stated)
REQ-030 Reset: assert rst_i=0 mid-clock -> outputs immediately ready_o=1, q_valid_o=0, q_o=0, done_o=0, last_o=0.
REQ-031 LSB_FIRST=0, tick_i=1 constant, send 0xA5 -> q_o = 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance; last_o only on cycle 8; done_o on cycle 9.
REQ-032 LSB_FIRST=1, tick_i=1, send 0x1E -> q_o = 0,1,1,1,1,0,0,0; last_o on bit 8.
REQ-033 Back-to-back: 0x0F then 0xF0, valid_i held, tick_i=1 -> 16 contiguous q_valid_o cycles, bits 0000111111110000; ready_o=1 only on IDLE and each 8th bit; done_o pulses twice.
REQ-034 Stall: send 0x80 with tick_i = 1,0,0,1,1... -> q_o=1 held for 3 cycles, then 0s; q_valid_o stays 1 throughout; total SHIFT duration 10 cycles.
REQ-035 Reset after 3 bits of 0xFF -> immediate IDLE, no done_o; after release, send 0x01 -> exactly 0,0,0,0,0,0,0,1 (MSB first).
